// File: rtl/cva6_stim_pkg.sv
// Shared constants, state type and instruction/response helpers for the
// CVA6 stimulus generator.
package cva6_stim_pkg;

    localparam logic [6:0]  OPC_LOAD    = 7'b0000011;
    localparam logic [6:0]  OPC_STORE   = 7'b0100011;
    localparam logic [6:0]  OPC_OP_IMM  = 7'b0010011;
    localparam logic [2:0]  F3_WORD     = 3'b010;
    localparam logic [31:0] INSTR_NOP   = 32'h0000_0013;
    localparam logic [31:0] LFSR_A_MASK = 32'h8020_0003;
    localparam logic [15:0] LFSR_B_MASK = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Instruction fields come from LFSR_A, funct3 for ALU ops from LFSR_B.
    // ld_wt / ldst_wt are cumulative class boundaries on the 4-bit selector.
    function automatic logic [31:0] build_instr(input logic [31:0] a,
                                                input logic [15:0] b,
                                                input logic [4:0]  ld_wt,
                                                input logic [4:0]  ldst_wt);
        logic [4:0]  sel;
        logic [11:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        sel = {1'b0, a[3:0]};
        imm = a[15:4];
        rs1 = a[20:16];
        rs2 = a[25:21];
        rd  = a[30:26];
        f3  = b[2:0];
        if (sel < ld_wt) begin
            build_instr = {imm, rs1, F3_WORD, rd, OPC_LOAD};
        end else if (sel < ldst_wt) begin
            build_instr = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OPC_STORE};
        end else begin
            // Shift-immediate forms only keep a legal shamt (plus SRAI bit).
            if (f3 == 3'd5)      imm = imm & 12'h41F;
            else if (f3 == 3'd1) imm = imm & 12'h01F;
            build_instr = {imm, rs1, f3, rd, OPC_OP_IMM};
        end
    endfunction

    // {store_hit, load_hit}: nibble compares against 0..16 thresholds, so a
    // threshold of 0 never hits and 16 always hits.
    function automatic logic [1:0] resp_hits(input logic [15:0] b,
                                             input logic [4:0]  ld_th,
                                             input logic [4:0]  st_th);
        resp_hits = {({1'b0, b[11:8]} < st_th), ({1'b0, b[7:4]} < ld_th)};
    endfunction

endpackage

// File: rtl/cva6_stim_gen_lfsr.sv
// stim_lfsr: right-shifting Galois LFSR with synchronous reseed.
// Ports: clk_i, rst_ni, step_i (advance one step), reseed_i (load SEED,
// wins over step_i), state_d_o (value the register holds after this edge).
module stim_lfsr #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] MASK  = '1,
    parameter logic [WIDTH-1:0] SEED  = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             step_i,
    input  logic             reseed_i,
    output logic [WIDTH-1:0] state_d_o
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] stepped;

    assign stepped = {1'b0, state_q[WIDTH-1:1]} ^ (state_q[0] ? MASK : '0);

    always_comb begin
        state_d_o = state_q;
        if (reseed_i)    state_d_o = SEED;
        else if (step_i) state_d_o = stepped;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= SEED;
        else         state_q <= state_d_o;
    end

endmodule

// File: rtl/cva6_stim_gen.sv
// cva6_stim_gen: random RV32I instruction source with valid/ready output and
// random load/store memory-response strobes.
// Ports: clk_i, rst_ni, en_i (run request), clear_i (sync restart),
// instr_o/instr_valid_o/instr_ready_i (instruction handshake),
// load_mem_resp_o/store_mem_resp_o (random responses while running),
// issued_cnt_o (accepted handshakes), done_o (NUM_INSTR reached).
//
// state | meaning
// IDLE  | nothing presented; waits for en_i
// RUN   | an instruction is always presented; advances on each handshake
// DONE  | NUM_INSTR handshakes accepted; waits for clear_i
module cva6_stim_gen
    import cva6_stim_pkg::*;
#(
    parameter int unsigned NUM_INSTR  = 16,
    parameter int unsigned CNT_W      = 16,
    parameter logic [31:0] SEED_A     = 32'h1234_5678,
    parameter logic [15:0] SEED_B     = 16'hACE1,
    parameter int unsigned LOAD_WT    = 4,
    parameter int unsigned STORE_WT   = 4,
    parameter int unsigned LD_RESP_TH = 8,
    parameter int unsigned ST_RESP_TH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clear_i,
    output logic [31:0]      instr_o,
    output logic             instr_valid_o,
    input  logic             instr_ready_i,
    output logic             load_mem_resp_o,
    output logic             store_mem_resp_o,
    output logic [CNT_W-1:0] issued_cnt_o,
    output logic             done_o
);

    localparam logic [4:0]       LD_WT   = 5'(LOAD_WT);
    localparam logic [4:0]       LDST_WT = 5'(LOAD_WT + STORE_WT);
    localparam logic [4:0]       LD_TH   = 5'(LD_RESP_TH);
    localparam logic [4:0]       ST_TH   = 5'(ST_RESP_TH);
    localparam logic [CNT_W-1:0] NUM_CNT = CNT_W'(NUM_INSTR);

    state_e           state_q;
    logic [31:0]      instr_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    logic [1:0]       resp_q;

    logic             hs;
    logic             last;
    logic             run_next;
    logic [CNT_W-1:0] cnt_inc;
    logic [31:0]      lfsr_a_d;
    logic [15:0]      lfsr_b_d;

    assign hs      = valid_q & instr_ready_i;
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign last    = (NUM_INSTR != 0) && (cnt_inc == NUM_CNT);

    // Whether the FSM will be in RUN after this edge; gates the response strobes.
    assign run_next = !clear_i &&
                      (((state_q == ST_IDLE) && en_i) ||
                       ((state_q == ST_RUN) && !(hs && (last || !en_i))));

    stim_lfsr #(.WIDTH(32), .MASK(LFSR_A_MASK), .SEED(SEED_A)) u_lfsr_a (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .step_i    (hs & ~clear_i),
        .reseed_i  (clear_i),
        .state_d_o (lfsr_a_d)
    );

    stim_lfsr #(.WIDTH(16), .MASK(LFSR_B_MASK), .SEED(SEED_B)) u_lfsr_b (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .step_i    ((state_q == ST_RUN) & ~clear_i),
        .reseed_i  (clear_i),
        .state_d_o (lfsr_b_d)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            resp_q  <= '0;
        end else if (clear_i) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            resp_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (en_i) begin
                        state_q <= ST_RUN;
                        instr_q <= INSTR_NOP;
                        valid_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (hs) begin
                        cnt_q <= cnt_inc;
                        if (last) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (!en_i) begin
                            state_q <= ST_IDLE;
                            valid_q <= 1'b0;
                        end else begin
                            instr_q <= build_instr(lfsr_a_d, lfsr_b_d, LD_WT, LDST_WT);
                        end
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
            resp_q <= run_next ? resp_hits(lfsr_b_d, LD_TH, ST_TH) : 2'b00;
        end
    end

    assign instr_o          = instr_q;
    assign instr_valid_o    = valid_q;
    assign issued_cnt_o     = cnt_q;
    assign done_o           = done_q;
    assign load_mem_resp_o  = resp_q[0];
    assign store_mem_resp_o = resp_q[1];

endmodule

// File: tb/tb_cva6_stim_gen.sv
// Testbench for cva6_stim_gen: four parameterisations share one stimulus
// stream; a reference model pushes expected instructions into per-instance
// queues and a negedge monitor pops them on every handshake.
module tb_cva6_stim_gen;

    localparam logic [31:0] SEED_A = 32'h1234_5678;
    localparam logic [15:0] SEED_B = 16'hACE1;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int NDUT = 4;
    // instance: 0 default-ish, 1 short run, 2 loads only, 3 ALU only + resp edges
    localparam int P_NUM  [NDUT] = '{40, 3, 0, 0};
    localparam int P_LDW  [NDUT] = '{4, 4, 16, 0};
    localparam int P_STW  [NDUT] = '{4, 4, 0, 0};
    localparam int P_LDTH [NDUT] = '{8, 8, 5, 0};
    localparam int P_STTH [NDUT] = '{8, 8, 11, 16};
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0, clr = 1'b0, rdy = 1'b0;

    logic [31:0] d_instr [NDUT];
    logic        d_valid [NDUT];
    logic        d_ld    [NDUT];
    logic        d_st    [NDUT];
    logic [15:0] d_cnt   [NDUT];
    logic        d_done  [NDUT];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        cva6_stim_gen #(
            .NUM_INSTR (P_NUM[g]),
            .CNT_W     (16),
            .SEED_A    (SEED_A),
            .SEED_B    (SEED_B),
            .LOAD_WT   (P_LDW[g]),
            .STORE_WT  (P_STW[g]),
            .LD_RESP_TH(P_LDTH[g]),
            .ST_RESP_TH(P_STTH[g])
        ) u_dut (
            .clk_i           (clk),
            .rst_ni          (rst_n),
            .en_i            (en),
            .clear_i         (clr),
            .instr_o         (d_instr[g]),
            .instr_valid_o   (d_valid[g]),
            .instr_ready_i   (rdy),
            .load_mem_resp_o (d_ld[g]),
            .store_mem_resp_o(d_st[g]),
            .issued_cnt_o    (d_cnt[g]),
            .done_o          (d_done[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] galois32(input logic [31:0] s);
        return (s >> 1) ^ (((s & 32'd1) != 0) ? 32'h8020_0003 : 32'd0);
    endfunction

    function automatic logic [15:0] galois16(input logic [15:0] s);
        return (s >> 1) ^ (((s & 16'd1) != 0) ? 16'hB400 : 16'd0);
    endfunction

    function automatic logic [31:0] model_instr(input logic [31:0] a, input logic [15:0] b,
                                                input int ldw, input int stw);
        logic [31:0] sel, imm, rs1, rs2, rd, f3;
        sel = a & 32'hF;
        imm = (a >> 4) & 32'hFFF;
        rs1 = (a >> 16) & 32'h1F;
        rs2 = (a >> 21) & 32'h1F;
        rd  = (a >> 26) & 32'h1F;
        f3  = 32'(b) & 32'h7;
        if (int'(sel) < ldw)
            return (imm << 20) | (rs1 << 15) | (32'd2 << 12) | (rd << 7) | 32'h03;
        if (int'(sel) < ldw + stw)
            return ((imm >> 5) << 25) | (rs2 << 20) | (rs1 << 15) | (32'd2 << 12)
                   | ((imm & 32'h1F) << 7) | 32'h23;
        if (f3 == 5) imm = imm & 32'h41F;
        else if (f3 == 1) imm = imm & 32'h01F;
        return (imm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
    endfunction

    int          mst    [NDUT];
    logic [31:0] ma     [NDUT];
    logic [15:0] mb     [NDUT];
    logic [15:0] mcnt   [NDUT];
    logic        mvalid [NDUT];
    logic        mdone  [NDUT];
    logic        mld    [NDUT];
    logic        mstr   [NDUT];
    logic [31:0] exp_q  [NDUT][$];
    logic [31:0] log_q  [NDUT][$];
    int          hs_cnt [NDUT];

    function automatic void model_restart(input int g);
        mst[g] = M_IDLE; ma[g] = SEED_A; mb[g] = SEED_B; mcnt[g] = '0;
        mvalid[g] = 1'b0; mdone[g] = 1'b0; mld[g] = 1'b0; mstr[g] = 1'b0;
        exp_q[g].delete();
    endfunction

    initial begin
        for (int g = 0; g < NDUT; g++) model_restart(g);
        forever begin
            @(posedge clk or negedge rst_n);
            for (int g = 0; g < NDUT; g++) begin
                if (!rst_n || clr) begin
                    model_restart(g);
                end else begin
                    case (mst[g])
                        M_IDLE: if (en) begin
                            mst[g] = M_RUN; mvalid[g] = 1'b1;
                            exp_q[g].push_back(NOP);
                        end
                        M_RUN: begin
                            mb[g] = galois16(mb[g]);
                            if (rdy) begin
                                mcnt[g] = mcnt[g] + 16'd1;
                                ma[g] = galois32(ma[g]);
                                if (P_NUM[g] != 0 && int'(mcnt[g]) == P_NUM[g]) begin
                                    mst[g] = M_DONE; mvalid[g] = 1'b0; mdone[g] = 1'b1;
                                end else if (!en) begin
                                    mst[g] = M_IDLE; mvalid[g] = 1'b0;
                                end else begin
                                    exp_q[g].push_back(model_instr(ma[g], mb[g], P_LDW[g], P_STW[g]));
                                end
                            end
                        end
                        default: ;
                    endcase
                    mld[g]  = (mst[g] == M_RUN) && (int'((mb[g] >> 4) & 16'hF) < P_LDTH[g]);
                    mstr[g] = (mst[g] == M_RUN) && (int'((mb[g] >> 8) & 16'hF) < P_STTH[g]);
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic        hold     [NDUT];
    logic [31:0] hold_val [NDUT];

    initial begin
        for (int g = 0; g < NDUT; g++) begin hold[g] = 1'b0; hold_val[g] = '0; hs_cnt[g] = 0; end
        forever begin
            @(negedge clk);
            for (int g = 0; g < NDUT; g++) begin
                logic [31:0] ins, imm;
                logic [2:0]  f3;
                ins = d_instr[g];
                chk($sformatf("g%0d_valid", g), 32'(d_valid[g]), 32'(mvalid[g]));
                chk($sformatf("g%0d_done", g),  32'(d_done[g]),  32'(mdone[g]));
                chk($sformatf("g%0d_cnt", g),   32'(d_cnt[g]),   32'(mcnt[g]));
                chk($sformatf("g%0d_ld_resp", g), 32'(d_ld[g]),  32'(mld[g]));
                chk($sformatf("g%0d_st_resp", g), 32'(d_st[g]),  32'(mstr[g]));
                if (!rst_n) begin
                    chk($sformatf("g%0d_rst_instr", g), ins, 32'd0);
                end else begin
                    if (hold[g]) chk($sformatf("g%0d_stall_hold", g), ins, hold_val[g]);
                    if (d_valid[g] && rdy && !clr) begin
                        hs_cnt[g]++;
                        log_q[g].push_back(ins);
                        if (exp_q[g].size() == 0) begin
                            checks++; errors++;
                            $display("FAIL g%0d_instr: got %h with no expected instruction queued", g, ins);
                        end else begin
                            chk($sformatf("g%0d_instr", g), ins, exp_q[g].pop_front());
                        end
                        f3  = ins[14:12];
                        imm = ins >> 20;
                        if (g == 2 && ins != NOP) begin
                            chk("g2_load_opcode", 32'(ins[6:0]), 32'h03);
                            chk("g2_load_funct3", 32'(f3), 32'd2);
                        end
                        if (g == 3) begin
                            chk("g3_alu_opcode", 32'(ins[6:0]), 32'h13);
                            if (f3 == 3'd5) chk("g3_srai_imm", imm & 32'hBE0, 32'd0);
                            if (f3 == 3'd1) chk("g3_slli_imm", imm & 32'hFE0, 32'd0);
                        end
                    end
                end
                hold[g]     = rst_n && !clr && d_valid[g] && !rdy;
                hold_val[g] = ins;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    logic [31:0] first_q [$];
    logic [31:0] run1_q  [$];
    logic        pat [30];

    initial begin
        for (int i = 0; i < 30; i++) pat[i] = ($urandom_range(0, 3) != 0);

        // reset state
        cyc(3);
        rst_n = 1'b1;
        cyc(1);

        // short bounded run on instance 1
        log_q[1].delete(); hs_cnt[1] = 0;
        en = 1'b1; rdy = 1'b1;
        cyc(8);
        en = 1'b0;
        cyc(4);
        chk("g1_hs_count", hs_cnt[1], 3);
        chk("g1_done", 32'(d_done[1]), 32'd1);
        chk("g1_issued", 32'(d_cnt[1]), 32'd3);
        chk("g1_first_nop", (log_q[1].size() > 0) ? log_q[1][0] : 32'hDEAD_BEEF, NOP);
        first_q = log_q[1];

        // clear out of DONE and rerun: same first three instructions
        clr = 1'b1; cyc(1); clr = 1'b0;
        log_q[1].delete(); hs_cnt[1] = 0;
        en = 1'b1; cyc(8); en = 1'b0; cyc(4);
        chk("g1_rerun_count", hs_cnt[1], 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("g1_rerun_%0d", i),
                (i < log_q[1].size()) ? log_q[1][i] : 32'hDEAD_BEEF,
                (i < first_q.size())  ? first_q[i]  : 32'hBAD0_BAD0);

        // 5-cycle stall mid-run
        clr = 1'b1; cyc(1); clr = 1'b0;
        en = 1'b1; rdy = 1'b1; cyc(4);
        rdy = 1'b0; cyc(5);
        rdy = 1'b1; cyc(4);

        // reference run, then async reset mid-run and replay
        en = 1'b0; rdy = 1'b0; clr = 1'b1; cyc(1); clr = 1'b0;
        log_q[0].delete();
        for (int i = 0; i < 30; i++) begin en = 1'b1; rdy = pat[i]; cyc(1); end
        run1_q = log_q[0];
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < NDUT; g++)
            chk($sformatf("g%0d_async_rst_valid", g), 32'(d_valid[g]), 32'd0);
        en = 1'b0; rdy = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        log_q[0].delete();
        for (int i = 0; i < 30; i++) begin en = 1'b1; rdy = pat[i]; cyc(1); end
        chk("replay_len", log_q[0].size(), run1_q.size());
        for (int i = 0; i < run1_q.size() && i < log_q[0].size(); i++)
            chk($sformatf("replay_%0d", i), log_q[0][i], run1_q[i]);

        // randomized traffic with enable drops and occasional clears
        for (int i = 0; i < 1500; i++) begin
            en  = ($urandom_range(0, 7) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 96) == 0);
            cyc(1);
        end
        en = 1'b0; rdy = 1'b1; clr = 1'b0;
        cyc(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
